// File: rtl/inbound_cmd_dispatch_pkg.sv
// inbound_cmd_dispatch_pkg: register map, STATUS/command-word field positions, dispatcher states.
// Rev 1.0
`default_nettype none

package inbound_cmd_dispatch_pkg;

  localparam logic [2:0] OFF_ADDR_LO  = 3'd0;
  localparam logic [2:0] OFF_ADDR_HI  = 3'd1;
  localparam logic [2:0] OFF_LEN      = 3'd2;
  localparam logic [2:0] OFF_DOORBELL = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam logic [31:0] ADDR_LO_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] LEN_MASK     = 32'h00FF_FFFF;

  localparam int STATUS_PEND_BIT = 31;

  localparam int CMD_CH_LSB      = 120;
  localparam int CMD_LEN_LSB     = 64;
  localparam int CMD_ADDR_HI_LSB = 32;
  localparam int CMD_ADDR_LO_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_PUSH = 2'd2
  } disp_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inbound_cmd_dispatch_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts one above the last accepted grant.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import inbound_cmd_dispatch_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && j == idx && req_i[j]) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          ptr_d    = PW'(j);
        end
      end
    end
  end

  // Pointer only moves when the grant is actually consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(N - 1);
    end else if (accept_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inbound_cmd_dispatch.sv
// inbound_cmd_dispatch: per-channel DMA command registers with doorbells, dispatched round-robin into an upstream FIFO.
// Rev 1.0
`default_nettype none

module inbound_cmd_dispatch
  import inbound_cmd_dispatch_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int REG_WORDS = 64,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [$clog2(REG_WORDS)-1:0] wr_addr_i,
  input  logic [3:0]                   wr_be_i,
  input  logic [31:0]                  wr_data_i,
  output logic                         wr_busy_o,
  input  logic [$clog2(REG_WORDS)-1:0] rd_addr_i,
  output logic [31:0]                  rd_data_o,
  input  logic                         us_cmd_fifo_full_i,
  input  logic                         us_cmd_fifo_prog_full_i,
  output logic [127:0]                 us_cmd_fifo_din_o,
  output logic                         us_cmd_fifo_wr_en_o,
  output logic                         rx_np_ok_o
);

  disp_state_e       state_q, state_d;
  logic [31:0]       addr_lo_q [NUM_CH];
  logic [31:0]       addr_lo_d [NUM_CH];
  logic [31:0]       addr_hi_q [NUM_CH];
  logic [31:0]       addr_hi_d [NUM_CH];
  logic [31:0]       len_q     [NUM_CH];
  logic [31:0]       len_d     [NUM_CH];
  logic [31:0]       sh_lo_q   [NUM_CH];
  logic [31:0]       sh_hi_q   [NUM_CH];
  logic [31:0]       sh_len_q  [NUM_CH];
  logic [CNT_W-1:0]  issued_q  [NUM_CH];
  logic [CNT_W-1:0]  issued_d  [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d, ring, gnt;
  logic [7:0]        gnt_ch_q, gnt_ch;
  logic              arb_accept, wr_accept, rx_np_ok_q;
  logic [31:0]       rd_data_q, rd_data_d;
  int                wr_ch, rd_ch;
  logic [2:0]        wr_off, rd_off;

  assign wr_ch      = int'(wr_addr_i) >> 3;
  assign wr_off     = wr_addr_i[2:0];
  assign rd_ch      = int'(rd_addr_i) >> 3;
  assign rd_off     = rd_addr_i[2:0];
  assign wr_accept  = wr_en_i & ~wr_busy_o;
  assign arb_accept = (state_q == ST_ARB) & ~us_cmd_fifo_full_i;
  assign rd_data_o  = rd_data_q;
  assign rx_np_ok_o = rx_np_ok_q;

  always_comb begin
    wr_busy_o = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == c && wr_off == OFF_DOORBELL && pending_q[c]) wr_busy_o = 1'b1;
    end
  end

  // A channel being pushed still has its pending bit set, so its doorbell stays busy through PUSH.
  always_comb begin
    addr_lo_d = addr_lo_q;
    addr_hi_d = addr_hi_q;
    len_d     = len_q;
    issued_d  = issued_q;
    pending_d = pending_q;
    ring      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_accept && wr_ch == c) begin
        case (wr_off)
          OFF_ADDR_LO:  addr_lo_d[c] = be_merge(addr_lo_q[c], wr_data_i, wr_be_i) & ADDR_LO_MASK;
          OFF_ADDR_HI:  addr_hi_d[c] = be_merge(addr_hi_q[c], wr_data_i, wr_be_i);
          OFF_LEN:      len_d[c]     = be_merge(len_q[c], wr_data_i, wr_be_i) & LEN_MASK;
          OFF_DOORBELL: ring[c]      = wr_data_i[0] & wr_be_i[0];
          default:      ;
        endcase
      end
      if (ring[c]) pending_d[c] = 1'b1;
      if (state_q == ST_PUSH && int'(gnt_ch_q) == c) begin
        pending_d[c] = 1'b0;
        issued_d[c]  = issued_q[c] + CNT_W'(1);
      end
    end
  end

  // Read mux works on next-state values so a same-edge write is visible.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == c) begin
        case (rd_off)
          OFF_ADDR_LO: rd_data_d = addr_lo_d[c];
          OFF_ADDR_HI: rd_data_d = addr_hi_d[c];
          OFF_LEN:     rd_data_d = len_d[c];
          OFF_STATUS: begin
            rd_data_d[CNT_W-1:0]       = issued_d[c];
            rd_data_d[STATUS_PEND_BIT] = pending_d[c];
          end
          default:     rd_data_d = '0;
        endcase
      end
    end
  end

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (pending_q),
    .accept_i (arb_accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    gnt_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) gnt_ch = 8'(c);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|pending_q && !us_cmd_fifo_full_i) state_d = ST_ARB;
      ST_ARB:  state_d = us_cmd_fifo_full_i ? ST_IDLE : ST_PUSH;
      ST_PUSH: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    us_cmd_fifo_wr_en_o = (state_q == ST_PUSH);
    us_cmd_fifo_din_o   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_q == ST_PUSH && int'(gnt_ch_q) == c) begin
        us_cmd_fifo_din_o[CMD_CH_LSB +: 8]       = gnt_ch_q;
        us_cmd_fifo_din_o[CMD_LEN_LSB +: 32]     = sh_len_q[c];
        us_cmd_fifo_din_o[CMD_ADDR_HI_LSB +: 32] = sh_hi_q[c];
        us_cmd_fifo_din_o[CMD_ADDR_LO_LSB +: 32] = sh_lo_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_ch_q   <= '0;
      pending_q  <= '0;
      rd_data_q  <= '0;
      rx_np_ok_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_lo_q[c] <= '0;
        addr_hi_q[c] <= '0;
        len_q[c]     <= '0;
        sh_lo_q[c]   <= '0;
        sh_hi_q[c]   <= '0;
        sh_len_q[c]  <= '0;
        issued_q[c]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      rx_np_ok_q <= ~(us_cmd_fifo_prog_full_i | (&pending_q));
      if (arb_accept) gnt_ch_q <= gnt_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_lo_q[c] <= addr_lo_d[c];
        addr_hi_q[c] <= addr_hi_d[c];
        len_q[c]     <= len_d[c];
        issued_q[c]  <= issued_d[c];
        if (ring[c]) begin
          sh_lo_q[c]  <= addr_lo_q[c];
          sh_hi_q[c]  <= addr_hi_q[c];
          sh_len_q[c] <= len_q[c];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inbound_cmd_dispatch.sv
// tb_inbound_cmd_dispatch: directed stimulus, register/dispatch model checked every cycle.
// Rev 1.0
`default_nettype none

module tb_inbound_cmd_dispatch;

  localparam int NUM_CH    = 4;
  localparam int REG_WORDS = 64;
  localparam int CNT_W     = 8;
  localparam int AW        = $clog2(REG_WORDS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [3:0]    wr_be_i = '0;
  logic [31:0]   wr_data_i = '0;
  logic          wr_busy_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic [31:0]   rd_data_o;
  logic          us_full = 1'b0;
  logic          us_prog = 1'b0;
  logic [127:0]  din;
  logic          wr_en;
  logic          np_ok;

  always #5 clk = ~clk;

  inbound_cmd_dispatch #(
    .NUM_CH    (NUM_CH),
    .REG_WORDS (REG_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .wr_en_i                 (wr_en_i),
    .wr_addr_i               (wr_addr_i),
    .wr_be_i                 (wr_be_i),
    .wr_data_i               (wr_data_i),
    .wr_busy_o               (wr_busy_o),
    .rd_addr_i               (rd_addr_i),
    .rd_data_o               (rd_data_o),
    .us_cmd_fifo_full_i      (us_full),
    .us_cmd_fifo_prog_full_i (us_prog),
    .us_cmd_fifo_din_o       (din),
    .us_cmd_fifo_wr_en_o     (wr_en),
    .rx_np_ok_o              (np_ok)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]       m_lo [NUM_CH];
  logic [31:0]       m_hi [NUM_CH];
  logic [31:0]       m_len[NUM_CH];
  logic [31:0]       s_lo [NUM_CH];
  logic [31:0]       s_hi [NUM_CH];
  logic [31:0]       s_len[NUM_CH];
  int                m_issued[NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_arb_pend, pend_snap;
  logic              m_arb_full, full_snap, busy_e;
  int                m_last, gc;
  logic [31:0]       m_rd_exp;
  logic              m_np_exp;
  int                push_cnt = 0;
  int                q_ch[$];
  logic [127:0]      q_din[$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = be[b/8] ? n[b] : o[b];
    return r;
  endfunction

  function automatic logic m_busy(input int a);
    return (a / 8 < NUM_CH) && (a % 8 == 3) && m_pend[a / 8];
  endfunction

  function automatic logic [31:0] m_read(input int a);
    int c, o;
    c = a / 8;
    o = a % 8;
    if (c >= NUM_CH) return 32'h0;
    case (o)
      0: return m_lo[c];
      1: return m_hi[c];
      2: return m_len[c];
      4: return 32'(m_issued[c]) | (m_pend[c] ? 32'h8000_0000 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input int a, input logic [3:0] be, input logic [31:0] d);
    int c, o;
    c = a / 8;
    o = a % 8;
    if (c >= NUM_CH) return;
    case (o)
      0: m_lo[c]  = merge(m_lo[c], d, be) & 32'hFFFF_FFFC;
      1: m_hi[c]  = merge(m_hi[c], d, be);
      2: m_len[c] = merge(m_len[c], d, be) & 32'h00FF_FFFF;
      3: if (d[0] && be[0]) begin
           m_pend[c] = 1'b1;
           s_lo[c] = m_lo[c]; s_hi[c] = m_hi[c]; s_len[c] = m_len[c];
         end
      default: ;
    endcase
  endfunction

  function automatic int m_choose();
    for (int i = 1; i <= NUM_CH; i++) begin
      if (m_arb_pend[(m_last + i) % NUM_CH]) return (m_last + i) % NUM_CH;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rd_data", rd_data_o, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_din", din, 0);
      check("rst_np_ok", np_ok, 0);
      for (int c = 0; c < NUM_CH; c++) begin
        m_lo[c] = 0; m_hi[c] = 0; m_len[c] = 0;
        s_lo[c] = 0; s_hi[c] = 0; s_len[c] = 0; m_issued[c] = 0;
      end
      m_pend = '0; m_arb_pend = '0; m_arb_full = 1'b1;
      m_last = NUM_CH - 1; m_rd_exp = 0; m_np_exp = 1'b0;
    end else begin
      check("rd_data", rd_data_o, m_rd_exp);
      check("rx_np_ok", np_ok, m_np_exp);
      busy_e = m_busy(int'(wr_addr_i));
      check("wr_busy", wr_busy_o, busy_e);
      pend_snap = m_pend;
      full_snap = us_full;
      if (wr_en) begin
        check("push_arb_had_request", |m_arb_pend, 1'b1);
        check("push_arb_fifo_not_full", m_arb_full, 1'b0);
        gc = m_choose();
        if (gc >= 0) begin
          check("push_din", din, {8'(gc), 24'h0, s_len[gc], s_hi[gc], s_lo[gc]});
          m_pend[gc] = 1'b0;
          m_issued[gc] = (m_issued[gc] + 1) % (1 << CNT_W);
          m_last = gc;
        end
        push_cnt++;
        q_ch.push_back(int'(din[127:120]));
        q_din.push_back(din);
      end else begin
        check("idle_din", din, 0);
      end
      if (wr_en_i && !busy_e) m_write(int'(wr_addr_i), wr_be_i, wr_data_i);
      m_np_exp   = !(us_prog || (&pend_snap));
      m_rd_exp   = m_read(int'(rd_addr_i));
      m_arb_pend = pend_snap;
      m_arb_full = full_snap;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_be_i = be; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    rd_addr_i = AW'(a);
    tick();
    d = rd_data_o;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_pushes(input string name, input int target, input int budget);
    for (int i = 0; i < budget && push_cnt < target; i++) tick();
    check(name, push_cnt, target);
  endtask

  logic [31:0] d;
  int base, i0;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rd(4, d);  check("status_after_reset", d, 0);
    rd(0, d);  check("addr_lo_after_reset", d, 0);

    wr(0, 4'hF, 32'h1234_5678);  rd(0, d);  check("ch0_addr_lo", d, 32'h1234_5678);
    wr(16, 4'hF, 32'hFFFF_FFFF); rd(16, d); check("ch2_addr_lo_align", d, 32'hFFFF_FFFC);
    wr(2, 4'h5, 32'h00AA_BBCC);  rd(2, d);  check("ch0_len_be5", d, 32'h00AA_00CC);
    wr(26, 4'hF, 32'hFFFF_FFFF); rd(26, d); check("ch3_len_mask", d, 32'h00FF_FFFF);
    wr(5, 4'hF, 32'hFFFF_FFFF);  rd(5, d);  check("reserved_word", d, 0);
    wr(40, 4'hF, 32'hFFFF_FFFF); rd(40, d); check("out_of_range", d, 0);

    wr(8, 4'hF, 32'h1000); wr(9, 4'hF, 32'h0); wr(10, 4'hF, 32'h40);
    base = push_cnt;
    wr(11, 4'hF, 32'h1);
    wait_pushes("ch1_push_within_3", base + 1, 3);
    check("ch1_din", q_din[q_din.size() - 1], 128'h01000000_00000040_00000000_00001000);
    repeat (3) tick();
    check("ch1_single_push", push_cnt, base + 1);
    rd(12, d); check("ch1_status", d, 32'h0000_0001);
    wr(11, 4'hE, 32'hFFFF_FFFF); wr(11, 4'hF, 32'h2);
    repeat (5) tick();
    check("no_ring_writes", push_cnt, base + 1);

    do_reset();
    wr(0, 4'hF, 32'h100); wr(16, 4'hF, 32'h200); wr(24, 4'hF, 32'h300);
    us_full = 1'b1;
    base = push_cnt; i0 = q_ch.size();
    wr(3, 4'hF, 1); wr(19, 4'hF, 1); wr(27, 4'hF, 1);
    wr_en_i = 1'b1; wr_addr_i = AW'(19); wr_be_i = 4'hF; wr_data_i = 32'h1;
    #1 check("ch2_redoorbell_busy", wr_busy_o, 1'b1);
    tick();
    wr_en_i = 1'b0;
    wr(16, 4'hF, 32'h9990);
    repeat (4) tick();
    check("no_push_while_full", push_cnt, base);
    us_full = 1'b0;
    wait_pushes("three_pushes", base + 3, 20);
    check("order_0", q_ch[i0], 0);
    check("order_1", q_ch[i0 + 1], 2);
    check("order_2", q_ch[i0 + 2], 3);
    check("ch2_shadow_lo", q_din[i0 + 1], {8'd2, 56'h0, 32'h0, 32'h200});
    repeat (3) tick();
    check("ch2_dropped_redoorbell", push_cnt, base + 3);

    base = push_cnt; i0 = q_ch.size();
    wr(19, 4'hF, 1);
    tick();
    us_full = 1'b1;
    wr(27, 4'hF, 1);
    repeat (4) tick();
    check("arb_abort_no_push", push_cnt, base);
    us_full = 1'b0;
    wait_pushes("after_abort_pushes", base + 2, 15);
    check("abort_order_0", q_ch[i0], 2);
    check("abort_order_1", q_ch[i0 + 1], 3);

    repeat (2) tick();
    us_prog = 1'b1; tick();
    check("np_ok_prog_full", np_ok, 1'b0);
    us_prog = 1'b0; tick();
    check("np_ok_restored", np_ok, 1'b1);
    us_full = 1'b1;
    base = push_cnt;
    wr(3, 4'hF, 1); wr(11, 4'hF, 1); wr(19, 4'hF, 1); wr(27, 4'hF, 1);
    tick();
    check("np_ok_all_pending", np_ok, 1'b0);
    us_full = 1'b0;
    wait_pushes("drain_all", base + 4, 30);

    do_reset();
    for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
      base = push_cnt;
      wr(3, 4'hF, 1);
      wait_pushes("wrap_loop_push", base + 1, 6);
    end
    rd(4, d); check("issued_max", d, 32'h0000_00FF);
    base = push_cnt;
    wr(3, 4'hF, 1);
    wait_pushes("wrap_last_push", base + 1, 6);
    rd(4, d); check("issued_wrapped", d, 32'h0);

    wr(8, 4'hF, 32'h40);
    base = push_cnt;
    wr(11, 4'hF, 1);
    tick(); tick();
    check("push_in_third_cycle", wr_en, 1'b1);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    repeat (5) tick();
    check("reset_suppressed_push", push_cnt, base);
    for (int c = 0; c < NUM_CH; c++) begin
      rd(8 * c + 4, d);
      check("status_after_mid_push_reset", d, 0);
    end
    rd(8, d); check("ch1_lo_after_reset", d, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
